// File: rtl/mc_seq_pkg.sv
// Shared definitions for the MC_outCtrl command sequencer.
//  - FSM state encoding
//  - channel width / legal channel range
//  - command record layout in the queue: {ch[MC_CH_W-1:0], hold[HOLD_W-1:0]}
package mc_seq_pkg;

  localparam int unsigned MC_CH_W   = 6;
  localparam int unsigned MC_CH_MAX = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CATCH = 3'd2,
    ST_POST  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_LATCH = 3'd5,
    ST_FIN   = 3'd6
  } seq_state_e;

  // Channels are numbered 1..MC_CH_MAX; 0 and anything above are dropped.
  function automatic logic ch_legal(input logic [MC_CH_W-1:0] ch);
    return (ch != '0) && (ch <= MC_CH_W'(MC_CH_MAX));
  endfunction

endpackage

// File: rtl/mc_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through read data.
// Ports:
//  clk, rst_n   clock, async active-low reset
//  flush        empties the queue; has priority over push/pop
//  push, wdata  write when push & ~full
//  pop          advance read pointer when pop & ~empty
//  rdata        head entry (valid while ~empty)
//  full, empty  occupancy flags derived from registered pointers
module mc_cmd_fifo #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage, no reset needed: entries are only read when written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mc_chan_sequencer.sv
// Upstream command stage for MC_outCtrl: queues channel-select commands and
// drives io_catch / ctrl / finish so ctrl is stable one cycle around the catch
// window and finish clears the level output after the programmed hold.
// Ports:
//  io_clk, io_rst            clock, async active-low reset
//  io_cmdValid/io_cmdReady   command handshake (ch 1..32, hold cycles)
//  io_cmdCh, io_cmdHold      command payload; hold 0 = keep level until next cmd/abort
//  io_abort                  flush queue, terminate current command
//  io_catch, ctrl, finish    to MC_outCtrl
//  io_busy                   sequencer not idle
//  io_err                    one-cycle pulse when an illegal channel is dropped
module mc_chan_sequencer
  import mc_seq_pkg::*;
#(
  parameter int unsigned CATCH_LEN  = 4,
  parameter int unsigned HOLD_W     = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               io_clk,
  input  logic               io_rst,
  input  logic               io_cmdValid,
  output logic               io_cmdReady,
  input  logic [MC_CH_W-1:0] io_cmdCh,
  input  logic [HOLD_W-1:0]  io_cmdHold,
  input  logic               io_abort,
  output logic               io_catch,
  output logic [MC_CH_W-1:0] ctrl,
  output logic               finish,
  output logic               io_busy,
  output logic               io_err
);

  localparam int unsigned CMD_W   = MC_CH_W + HOLD_W;
  localparam int unsigned CATCH_W = $clog2(CATCH_LEN + 1);

  seq_state_e          state_q, state_d;
  logic [MC_CH_W-1:0]  ch_q, ch_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CATCH_W-1:0]  catch_cnt_q, catch_cnt_d;
  logic                abort_pend_q, abort_pend_d;
  logic                rst_done_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                fifo_push;
  logic [CMD_W-1:0]    fifo_rdata;
  logic [MC_CH_W-1:0]  head_ch;
  logic [HOLD_W-1:0]   head_hold;
  logic                cmd_fire;
  logic                cmd_legal;

  // Abort gates ready directly so a push in the abort cycle is refused.
  assign io_cmdReady = rst_done_q & ~fifo_full & ~io_abort;
  assign cmd_fire    = io_cmdValid & io_cmdReady;
  assign cmd_legal   = ch_legal(io_cmdCh);
  assign fifo_push   = cmd_fire & cmd_legal;
  assign head_ch     = fifo_rdata[CMD_W-1 -: MC_CH_W];
  assign head_hold   = fifo_rdata[HOLD_W-1:0];

  mc_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (io_clk),
    .rst_n (io_rst),
    .flush (io_abort),
    .push  (fifo_push),
    .wdata ({io_cmdCh, io_cmdHold}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state / counter logic
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    hold_cnt_d   = hold_cnt_q;
    catch_cnt_d  = catch_cnt_q;
    abort_pend_d = abort_pend_q;
    fifo_pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !io_abort) begin
          fifo_pop   = 1'b1;
          ch_d       = head_ch;
          hold_cnt_d = head_hold;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        catch_cnt_d = CATCH_W'(CATCH_LEN);
        state_d     = ST_CATCH;
        if (io_abort) abort_pend_d = 1'b1;
      end
      ST_CATCH: begin
        if (io_abort) abort_pend_d = 1'b1;
        if (catch_cnt_q == CATCH_W'(1)) state_d = ST_POST;
        else catch_cnt_d = catch_cnt_q - CATCH_W'(1);
      end
      ST_POST: begin
        // The catch window is complete; an abort seen during it ends here.
        if (abort_pend_q || io_abort) state_d = ST_FIN;
        else if (hold_cnt_q == '0)    state_d = ST_LATCH;
        else                          state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (io_abort || hold_cnt_q == HOLD_W'(1)) state_d = ST_FIN;
        else hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
      ST_LATCH: begin
        if (io_abort) begin
          state_d = ST_FIN;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          ch_d       = head_ch;
          hold_cnt_d = head_hold;
          state_d    = ST_SETUP;
        end
      end
      ST_FIN: begin
        abort_pend_d = 1'b0;
        if (!fifo_empty && !io_abort) begin
          fifo_pop   = 1'b1;
          ch_d       = head_ch;
          hold_cnt_d = head_hold;
          state_d    = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; outputs decode the next state so they line up with it.
  always_ff @(posedge io_clk or negedge io_rst) begin
    if (!io_rst) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      hold_cnt_q   <= '0;
      catch_cnt_q  <= '0;
      abort_pend_q <= 1'b0;
      rst_done_q   <= 1'b0;
      io_catch     <= 1'b0;
      ctrl         <= '0;
      finish       <= 1'b0;
      io_busy      <= 1'b0;
      io_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      hold_cnt_q   <= hold_cnt_d;
      catch_cnt_q  <= catch_cnt_d;
      abort_pend_q <= abort_pend_d;
      rst_done_q   <= 1'b1;
      io_catch     <= (state_d == ST_CATCH);
      ctrl         <= (state_d == ST_IDLE) ? '0 : ch_d;
      finish       <= (state_d == ST_FIN);
      io_busy      <= (state_d != ST_IDLE);
      io_err       <= cmd_fire & ~cmd_legal;
    end
  end

endmodule

// File: tb/tb_mc_chan_sequencer.sv
// Directed bench for mc_chan_sequencer with a channel scoreboard and a
// behavioural MC_outCtrl level-output model (latch on catch fall, clear on finish).
module tb_mc_chan_sequencer;

  localparam int unsigned CATCH_LEN  = 4;
  localparam int unsigned HOLD_W     = 24;
  localparam int unsigned FIFO_DEPTH = 4;

  logic              io_clk = 1'b0;
  logic              io_rst = 1'b0;
  logic              io_cmdValid = 1'b0;
  logic              io_cmdReady;
  logic [5:0]        io_cmdCh = '0;
  logic [HOLD_W-1:0] io_cmdHold = '0;
  logic              io_abort = 1'b0;
  logic              io_catch;
  logic [5:0]        ctrl;
  logic              finish;
  logic              io_busy;
  logic              io_err;

  mc_chan_sequencer #(
    .CATCH_LEN  (CATCH_LEN),
    .HOLD_W     (HOLD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .io_clk      (io_clk),
    .io_rst      (io_rst),
    .io_cmdValid (io_cmdValid),
    .io_cmdReady (io_cmdReady),
    .io_cmdCh    (io_cmdCh),
    .io_cmdHold  (io_cmdHold),
    .io_abort    (io_abort),
    .io_catch    (io_catch),
    .ctrl        (ctrl),
    .finish      (finish),
    .io_busy     (io_busy),
    .io_err      (io_err)
  );

  always #5 io_clk = ~io_clk;

  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          sb[$];
  logic        prev_catch = 1'b0;
  logic [5:0]  prev_ctrl = '0;
  int          cur_ch = 0;
  int          catch_len = 0;
  int          fin_cnt = 0;
  int          err_cnt = 0;
  int          rise_cnt = 0;
  int          idle_cnt = 0;
  int          rise_cyc = 0;
  int          fall_cyc = 0;
  int          fin_cyc = 0;
  int          acc_cyc = 0;
  logic [31:0] lev = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Observes outputs once per cycle: scoreboard on catch rise, window checks, level model.
  task automatic monitor();
    if (!io_busy) idle_cnt++;
    if (io_err) err_cnt++;
    if (finish) begin
      fin_cnt++;
      fin_cyc = cyc;
      lev = '0;
    end
    if (io_catch && !prev_catch) begin
      rise_cnt++;
      rise_cyc  = cyc;
      catch_len = 1;
      check("sb_has_entry", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        cur_ch = sb.pop_front();
        check("ctrl_at_rise", 64'(ctrl), 64'(cur_ch));
        check("ctrl_before_rise", 64'(prev_ctrl), 64'(cur_ch));
      end
    end else if (io_catch && prev_catch) begin
      catch_len++;
      check("ctrl_in_catch", 64'(ctrl), 64'(cur_ch));
    end else if (!io_catch && prev_catch) begin
      fall_cyc = cyc;
      check("catch_len", 64'(catch_len), 64'(CATCH_LEN));
      check("ctrl_after_fall", 64'(ctrl), 64'(cur_ch));
      check("no_finish_at_fall", 64'(finish), 64'(0));
      if (ctrl >= 6'd1 && ctrl <= 6'd32) lev = 32'd1 << (ctrl - 6'd1);
      else lev = '0;
      check("lev_onehot", 64'(lev), 64'(32'd1 << (cur_ch - 1)));
    end
    prev_catch = io_catch;
    prev_ctrl  = ctrl;
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one command until accepted (bounded); legal channels go to the scoreboard.
  task automatic push(input int c, input int h);
    bit done;
    done        = 1'b0;
    io_cmdValid = 1'b1;
    io_cmdCh    = 6'(c);
    io_cmdHold  = HOLD_W'(h);
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (io_cmdReady) begin
        done = 1'b1;
        if (c >= 1 && c <= 32) sb.push_back(c);
      end
      tick();
    end
    io_cmdValid = 1'b0;
    acc_cyc = cyc;
    check("push_accepted", 64'(done), 64'(1));
  endtask

  task automatic wait_fin(input int target, input int budget);
    for (int i = 0; i < budget && fin_cnt < target; i++) tick();
    check("wait_finish", 64'(fin_cnt >= target), 64'(1));
  endtask

  initial begin
    int k, base_fin, base_err, base_rise, idle0;

    // Reset values
    #12;
    check("reset_outputs", 64'({io_catch, ctrl, finish, io_busy, io_err, io_cmdReady}), 64'(0));
    @(posedge io_clk);
    #1;
    io_rst = 1'b1;
    #1;
    check("ready_before_first_edge", 64'(io_cmdReady), 64'(0));
    tick();
    check("ready_after_release", 64'(io_cmdReady), 64'(1));

    // 1: single command, ch 5 hold 10
    push(5, 10);
    k = acc_cyc;
    tick();
    check("t1_setup_ctrl", 64'({ctrl, io_catch}), 64'({6'd5, 1'b0}));
    wait_fin(1, 40);
    check("t1_rise_cyc", 64'(rise_cyc), 64'(k + 2));
    check("t1_fall_cyc", 64'(fall_cyc), 64'(k + 2 + CATCH_LEN));
    check("t1_fin_cyc", 64'(fin_cyc), 64'(k + 2 + CATCH_LEN + 1 + 10));
    tick();
    check("t1_idle", 64'({ctrl, io_busy}), 64'(0));
    check("t1_lev_cleared", 64'(lev), 64'(0));

    // 2: back-to-back queue fill, ready drops when full, order and no idle gaps
    base_fin = fin_cnt;
    push(1, 2);
    push(32, 2);
    idle0 = idle_cnt;
    push(7, 2);
    push(3, 2);
    push(14, 2);
    io_cmdValid = 1'b1;
    io_cmdCh    = 6'd25;
    #1;
    check("t2_ready_when_full", 64'(io_cmdReady), 64'(0));
    push(25, 2);
    wait_fin(base_fin + 6, 200);
    check("t2_no_idle_between", 64'(idle_cnt - idle0), 64'(0));
    tick();
    check("t2_idle_after", 64'(io_busy), 64'(0));
    check("t2_sb_drained", 64'(sb.size()), 64'(0));

    // 3: illegal channels
    base_err  = err_cnt;
    base_rise = rise_cnt;
    push(0, 5);
    check("t3_err_ch0", 64'(io_err), 64'(1));
    push(33, 5);
    check("t3_err_ch33", 64'(io_err), 64'(1));
    tick();
    check("t3_err_single", 64'(io_err), 64'(0));
    ticks(8);
    check("t3_err_count", 64'(err_cnt - base_err), 64'(2));
    check("t3_no_catch", 64'(rise_cnt - base_rise), 64'(0));
    check("t3_idle", 64'(io_busy), 64'(0));

    // 4: hold 0 latches, next command re-sequences without finish, abort finishes
    base_fin = fin_cnt;
    push(9, 0);
    ticks(12);
    check("t4_latched", 64'({io_busy, ctrl}), 64'({1'b1, 6'd9}));
    check("t4_lev9", 64'(lev), 64'(32'd1 << 8));
    push(12, 0);
    tick();
    check("t4_setup12", 64'({ctrl, io_catch}), 64'({6'd12, 1'b0}));
    ticks(10);
    check("t4_no_finish", 64'(fin_cnt - base_fin), 64'(0));
    check("t4_lev12", 64'(lev), 64'(32'd1 << 11));
    io_abort = 1'b1;
    sb.delete();
    tick();
    io_abort = 1'b0;
    check("t4_abort_finish", 64'(finish), 64'(1));
    tick();
    check("t4_idle", 64'({io_busy, ctrl}), 64'(0));
    check("t4_one_finish", 64'(fin_cnt - base_fin), 64'(1));

    // 5: abort during catch with two commands queued
    base_fin  = fin_cnt;
    base_rise = rise_cnt;
    push(6, 3);
    push(10, 3);
    push(11, 3);
    check("t5_in_catch", 64'(io_catch), 64'(1));
    io_abort = 1'b1;
    sb.delete();
    tick();
    io_abort = 1'b0;
    wait_fin(base_fin + 1, 30);
    check("t5_fin_after_post", 64'(fin_cyc - fall_cyc), 64'(1));
    ticks(8);
    check("t5_idle", 64'(io_busy), 64'(0));
    check("t5_one_catch", 64'(rise_cnt - base_rise), 64'(1));
    check("t5_one_finish", 64'(fin_cnt - base_fin), 64'(1));

    // 6: reset during hold
    push(17, 20);
    ticks(9);
    check("t6_in_hold", 64'({io_busy, io_catch, ctrl}), 64'({1'b1, 1'b0, 6'd17}));
    base_fin = fin_cnt;
    io_rst = 1'b0;
    lev = '0;
    #1;
    check("t6_reset_outputs", 64'({io_catch, ctrl, finish, io_busy, io_err, io_cmdReady}), 64'(0));
    ticks(2);
    io_rst = 1'b1;
    tick();
    check("t6_ready_after", 64'(io_cmdReady), 64'(1));
    ticks(6);
    check("t6_fifo_empty", 64'(io_busy), 64'(0));
    check("t6_no_finish", 64'(fin_cnt - base_fin), 64'(0));

    // Hold of 1 gives a single hold cycle
    push(2, 1);
    wait_fin(base_fin + 1, 30);
    check("hold1_timing", 64'(fin_cyc - fall_cyc), 64'(2));
    ticks(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
